simmem_bank_timer: RTL

SIMMEM_BANK_TIMER -- requirements
Module: simmem_bank_timer

---
 rtl/simmem_bank_timer.sv | 107 ++++++++++
 1 files changed

// File: rtl/simmem_bank_timer.sv
// simmem_bank_timer: per-bank row-buffer latency timer with fixed-priority completion (define SIMMEM_AUTO_PRECHARGE_EN for closed-page policy)
package simmem_pkg;
  localparam int GlobalMemCapaW = 19;
  localparam int RowBufLenW = 10;
  localparam int RowHitCost = 4;
  localparam int PrechargeCost = 2;
  localparam int ActivationCost = 1;
  localparam int WRspBankAddrW = 4;
endpackage

module simmem_bank_timer #(
  parameter int NumBanks = 4,
  parameter int AddrW = simmem_pkg::GlobalMemCapaW,
  parameter int RowBufLenW = simmem_pkg::RowBufLenW,
  parameter int HitCost = simmem_pkg::RowHitCost,
  parameter int PrechCost = simmem_pkg::PrechargeCost,
  parameter int ActCost = simmem_pkg::ActivationCost,
  parameter int IidW = simmem_pkg::WRspBankAddrW,
  localparam int BankW = $clog2(NumBanks),
  localparam int DelayW = $clog2(HitCost + PrechCost + ActCost + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AddrW-1:0]  req_addr_i,
  input  logic [IidW-1:0]   req_iid_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IidW-1:0]   rsp_iid_o,
  output logic [DelayW-1:0] rsp_delay_o,
  output logic              rsp_hit_o
);
  localparam int RowW = AddrW - RowBufLenW - BankW;
  localparam logic [DelayW-1:0] HitD = DelayW'(HitCost);
  localparam logic [DelayW-1:0] ActD = DelayW'(ActCost);
  localparam logic [DelayW-1:0] PrechD = DelayW'(PrechCost);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q [NumBanks];
  state_e state_d [NumBanks];
  logic [NumBanks-1:0] row_open_q, hit_q;
  logic [RowW-1:0] open_row_q [NumBanks];
  logic [IidW-1:0] iid_q [NumBanks];
  logic [DelayW-1:0] delay_q [NumBanks];
  logic [DelayW-1:0] cnt_q [NumBanks];
  logic [BankW-1:0] req_bank, lowest, sel, sel_q;
  logic [RowW-1:0] req_row;
  logic [DelayW-1:0] req_delay;
  logic accept, hit, any_done, locked_q, rsp_hs, unused_offset;
  assign unused_offset = ^req_addr_i[RowBufLenW-1:0];
  assign req_bank = req_addr_i[RowBufLenW +: BankW];
  assign req_row = req_addr_i[AddrW-1 -: RowW];
  assign req_ready_o = state_q[req_bank] == IDLE;
  assign accept = req_valid_i && req_ready_o;
  assign hit = row_open_q[req_bank] && open_row_q[req_bank] == req_row;
  assign req_delay = hit ? HitD : !row_open_q[req_bank] ? ActD + HitD : PrechD + ActD + HitD;
  always_comb begin
    any_done = 1'b0;
    lowest = '0;
    for (int i = NumBanks - 1; i >= 0; i--) begin
      any_done = any_done || state_q[i] == DONE;
      lowest = state_q[i] == DONE ? BankW'(i) : lowest;
    end
  end
  assign sel = locked_q ? sel_q : lowest;
  assign rsp_valid_o = any_done;
  assign rsp_hs = rsp_valid_o && rsp_ready_i;
  assign rsp_iid_o = rsp_valid_o ? iid_q[sel] : '0;
  assign rsp_delay_o = rsp_valid_o ? delay_q[sel] : '0;
  assign rsp_hit_o = rsp_valid_o && hit_q[sel];
  always_comb begin
    for (int i = 0; i < NumBanks; i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] == IDLE && accept && req_bank == BankW'(i))
        state_d[i] = req_delay == DelayW'(1) ? DONE : BUSY;
      else if (state_q[i] == BUSY && cnt_q[i] == DelayW'(1))
        state_d[i] = DONE;
      else if (state_q[i] == DONE && rsp_hs && sel == BankW'(i))
        state_d[i] = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumBanks; i++) state_q[i] <= IDLE;
      row_open_q <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      locked_q <= rsp_valid_o && !rsp_ready_i;
      sel_q <= sel;
      for (int i = 0; i < NumBanks; i++) begin
        if (state_q[i] == BUSY) cnt_q[i] <= cnt_q[i] - DelayW'(1);
        if (accept && req_bank == BankW'(i)) begin
          cnt_q[i] <= req_delay - DelayW'(1);
          delay_q[i] <= req_delay;
          hit_q[i] <= hit;
          iid_q[i] <= req_iid_i;
          row_open_q[i] <= 1'b1;
          open_row_q[i] <= req_row;
        end
      end
`ifdef SIMMEM_AUTO_PRECHARGE_EN
      if (rsp_hs) row_open_q[sel] <= 1'b0;
`endif
    end
  end
endmodule
